aux_regs_mbox: RTL and testbench

- Per-lane auxiliary register block, next generation of the lane aux-register unit.
- Decodes register-move commands into:
  - NUM_PIPE one-hot pipeline-register read enables.
  - A NUM_CONST-entry constant register file.
  - A bidirectional scalar mailbox: one FIFO from lane to scalar unit, one from scalar unit to lane.
- Sits beside the lane register-read/write-back path. Exchanges scalar data with the scalar unit through valid/ready handshakes and raises a stall when the mailbox cannot service a move.

---
 rtl/pkg_tpu.sv | 44 ++++
 rtl/aux_sfifo.sv | 55 +++++
 rtl/aux_regs_mbox.sv | 128 ++++++++++++
 tb/tb_aux_regs_mbox.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_tpu.sv
// pkg_tpu: shared TPU lane types plus aux-register move decode constants.
package pkg_tpu;

   localparam int DATA_W    = 32;
   localparam int ID_W      = 4;
   localparam int AUX_IDX_W = 5;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ID_W-1:0]   id_t;

   localparam logic [1:0] AUX_OPTYPE_MOVE  = 2'b00;
   localparam logic [1:0] AUX_OPCLASS_MOVE = 2'b11;
   localparam logic [1:0] AUX_OPCODE_RD    = 2'b10;
   localparam logic [1:0] AUX_OPCODE_WT    = 2'b11;

   localparam int AUX_CONST_BASE = 4;
   localparam int AUX_SCALAR_IDX = 8;

   typedef struct packed {
      logic [1:0] OpType;
      logic [1:0] OpClass;
      logic [1:0] OpCode;
   } aux_op_t;

   typedef struct packed {
      logic                 v;
      logic [AUX_IDX_W-1:0] idx;
   } aux_src_t;

   typedef struct packed {
      aux_op_t  op;
      aux_src_t src1;
   } pipe_index_t;

   typedef struct packed {
      data_t data;
      id_t   tid;
   } mbox_entry_t;

   function automatic logic is_move(input aux_op_t op, input logic [1:0] code);
      return op.OpType == AUX_OPTYPE_MOVE && op.OpClass == AUX_OPCLASS_MOVE && op.OpCode == code;
   endfunction

endpackage

// File: rtl/aux_sfifo.sv
// aux_sfifo: generic synchronous FIFO; push while full is accepted only when a pop frees a slot
// in the same cycle, and the head reads as zero when empty.
module aux_sfifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [7:0]
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  T                           data_i,
   output T                           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   T                mem_q [DEPTH];
   logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            push_ok, pop_ok;

   assign full_o  = cnt_q == CW'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign count_o = cnt_q;
   assign data_o  = empty_o ? '0 : mem_q[rd_q];
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);

   always_comb begin
      wr_d  = push_ok ? wr_q + PW'(1) : wr_q;
      rd_d  = pop_ok ? rd_q + PW'(1) : rd_q;
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: the head is masked while empty.
   always_ff @(posedge clock)
      if (push_ok) mem_q[wr_q] <= data_i;

endmodule

// File: rtl/aux_regs_mbox.sv
// aux_regs_mbox: per-lane aux registers (pipe-reg selects, constant file, scalar mailbox).
// Define AUX_MBOX_BYPASS_EN to forward a same-cycle scalar push to a read of the empty inbound FIFO.
module aux_regs_mbox
   import pkg_tpu::*;
#(
   parameter int LANE_ID    = 0,
   parameter int NUM_PIPE   = 2,
   parameter int NUM_CONST  = 4,
   parameter int CONST_BASE = AUX_CONST_BASE,
   parameter int SCALAR_IDX = AUX_SCALAR_IDX,
   parameter int MBOX_DEPTH = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                I_Stall,
   input  id_t                 I_ThreadID,
   input  logic                I_Re,
   input  logic                I_We,
   input  pipe_index_t         I_Src_Command,
   input  data_t               I_Data,
   output logic [NUM_PIPE-1:0] O_Re_p,
   output logic                O_Re_c,
   output data_t               O_Data,
   output logic                O_Stall,
   input  logic                I_SWe,
   output logic                O_SRdy,
   input  data_t               I_Scalar_Data,
   output logic                O_Scl_Valid,
   input  logic                I_Scl_Ready,
   output data_t               O_Scalar_Data,
   output id_t                 O_Scl_TID,
   output logic [7:0]          O_Scl_LaneID
);

   localparam int CNT_W  = $clog2(MBOX_DEPTH+1);
   localparam int CSEL_W = NUM_CONST > 1 ? $clog2(NUM_CONST) : 1;

   logic [AUX_IDX_W-1:0] idx, const_off;
   logic [CSEL_W-1:0]    const_sel;
   logic                 mv_rd, mv_wt, hit_const, hit_mbox, rd_mbox, wt_mbox, const_we;
   logic                 byp;
   data_t                const_q [NUM_CONST];
   data_t                const_d [NUM_CONST];

   logic                 out_push, out_pop, out_full, out_empty;
   logic                 in_push, in_pop, in_full, in_empty;
   logic [CNT_W-1:0]     out_cnt, in_cnt;
   mbox_entry_t          out_din, out_head;
   data_t                in_head;
   logic                 unused_cnt;

   assign idx       = I_Src_Command.src1.idx;
   assign mv_rd     = I_Re & is_move(I_Src_Command.op, AUX_OPCODE_RD);
   assign mv_wt     = I_We & is_move(I_Src_Command.op, AUX_OPCODE_WT);
   assign hit_const = idx >= AUX_IDX_W'(CONST_BASE) && idx < AUX_IDX_W'(CONST_BASE + NUM_CONST);
   assign hit_mbox  = idx == AUX_IDX_W'(SCALAR_IDX);
   assign rd_mbox   = mv_rd & hit_mbox;
   assign wt_mbox   = mv_wt & hit_mbox;
   assign const_off = idx - AUX_IDX_W'(CONST_BASE);
   assign const_sel = const_off[CSEL_W-1:0];
   assign const_we  = mv_wt & hit_const & ~I_Stall;

   for (genvar k = 0; k < NUM_PIPE; k++) begin : g_re_p
      assign O_Re_p[k] = mv_rd & I_Src_Command.src1.v & (idx == AUX_IDX_W'(k));
   end

   always_comb begin
      const_d = const_q;
      if (const_we) const_d[const_sel] = I_Data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < NUM_CONST; k++) const_q[k] <= '0;
      end else begin
         const_q <= const_d;
      end
   end

`ifdef AUX_MBOX_BYPASS_EN
   assign byp = rd_mbox & in_empty & I_SWe;
`else
   assign byp = 1'b0;
`endif

   assign out_pop  = O_Scl_Valid & I_Scl_Ready;
   assign out_push = wt_mbox & ~I_Stall;
   assign out_din  = '{data: I_Data, tid: I_ThreadID};

   // A lane pop frees a slot, so a full inbound FIFO may still accept that cycle.
   assign in_pop   = rd_mbox & ~in_empty & ~I_Stall;
   assign O_SRdy   = ~in_full | in_pop;
   assign in_push  = I_SWe & O_SRdy & ~byp;

   aux_sfifo #(.DEPTH(MBOX_DEPTH), .T(mbox_entry_t)) u_out_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (out_push),
      .pop_i   (out_pop),
      .data_i  (out_din),
      .data_o  (out_head),
      .full_o  (out_full),
      .empty_o (out_empty),
      .count_o (out_cnt)
   );

   aux_sfifo #(.DEPTH(MBOX_DEPTH), .T(data_t)) u_in_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (in_push),
      .pop_i   (in_pop),
      .data_i  (I_Scalar_Data),
      .data_o  (in_head),
      .full_o  (in_full),
      .empty_o (in_empty),
      .count_o (in_cnt)
   );

   assign unused_cnt    = ^{out_cnt, in_cnt};
   assign O_Re_c        = mv_rd & hit_const;
   assign O_Data        = O_Re_c ? const_q[const_sel] : rd_mbox ? (byp ? I_Scalar_Data : in_head) : '0;
   assign O_Stall       = (wt_mbox & out_full & ~out_pop) | (rd_mbox & in_empty & ~byp);
   assign O_Scl_Valid   = ~out_empty;
   assign O_Scalar_Data = out_head.data;
   assign O_Scl_TID     = out_head.tid;
   assign O_Scl_LaneID  = 8'(LANE_ID);

endmodule

// File: tb/tb_aux_regs_mbox.sv
// tb_aux_regs_mbox: directed and randomized checks of aux_regs_mbox against a queue-based model.
module tb_aux_regs_mbox;
   import pkg_tpu::*;

   logic        clock = 1'b0, reset = 1'b1;
   logic        I_Stall = 1'b0, I_Re = 1'b0, I_We = 1'b0, I_SWe = 1'b0, I_Scl_Ready = 1'b0;
   id_t         I_ThreadID = '0;
   pipe_index_t I_Src_Command = '0;
   data_t       I_Data = '0, I_Scalar_Data = '0;
   logic [1:0]  O_Re_p;
   logic        O_Re_c, O_Stall, O_SRdy, O_Scl_Valid;
   data_t       O_Data, O_Scalar_Data;
   id_t         O_Scl_TID;
   logic [7:0]  O_Scl_LaneID;

   int          n_cmp = 0, n_err = 0;
   data_t       cm [4];
   data_t       inq [$];
   mbox_entry_t outq [$];

   aux_regs_mbox dut (
      .clock         (clock),
      .reset         (reset),
      .I_Stall       (I_Stall),
      .I_ThreadID    (I_ThreadID),
      .I_Re          (I_Re),
      .I_We          (I_We),
      .I_Src_Command (I_Src_Command),
      .I_Data        (I_Data),
      .O_Re_p        (O_Re_p),
      .O_Re_c        (O_Re_c),
      .O_Data        (O_Data),
      .O_Stall       (O_Stall),
      .I_SWe         (I_SWe),
      .O_SRdy        (O_SRdy),
      .I_Scalar_Data (I_Scalar_Data),
      .O_Scl_Valid   (O_Scl_Valid),
      .I_Scl_Ready   (I_Scl_Ready),
      .O_Scalar_Data (O_Scalar_Data),
      .O_Scl_TID     (O_Scl_TID),
      .O_Scl_LaneID  (O_Scl_LaneID)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic cmd(input bit rd, input bit wt, input int idx, input bit v = 1'b1);
      I_Re = rd;
      I_We = wt;
      I_Src_Command.op = '{OpType: 2'b00, OpClass: 2'b11, OpCode: wt ? 2'b11 : 2'b10};
      I_Src_Command.src1.v = v;
      I_Src_Command.src1.idx = 5'(idx);
   endtask

   initial begin
      int idx;
      bit rd, wt, inc, mb, byp, out_pop, in_pop, push_out, srdy, stall_e;
      data_t ed;
      logic [1:0] er;
      logic [3:0] vals [4];
      data_t in_exp [4];
      vals = '{4'd1, 4'd2, 4'd3, 4'd4};
      in_exp = '{32'hA1, 32'hA2, 32'hA3, 32'hB0};

      repeat (2) cyc();
      reset = 1'b0;
      #1;
      chk("rst_valid", O_Scl_Valid, 0);
      chk("rst_srdy", O_SRdy, 1);
      chk("rst_stall", O_Stall, 0);
      chk("rst_data", O_Data, 0);
      chk("rst_sdata", O_Scalar_Data, 0);
      chk("rst_tid", O_Scl_TID, 0);
      chk("rst_rep", O_Re_p, 0);
      chk("lane_id", O_Scl_LaneID, 0);

      cmd(1, 0, 1);
      #1;
      chk("rep_idx1", O_Re_p, 2'b10);
      chk("rec_idx1", O_Re_c, 0);
      chk("stall_idx1", O_Stall, 0);
      cmd(1, 0, 0, 0);
      #1;
      chk("rep_novalid", O_Re_p, 2'b00);
      cmd(1, 0, 0);
      #1;
      chk("rep_idx0", O_Re_p, 2'b01);

      cmd(0, 1, 5);
      I_Data = 32'hDEADBEEF;
      cyc();
      cmd(1, 0, 5);
      #1;
      chk("const_rd", O_Data, 32'hDEADBEEF);
      chk("const_rec", O_Re_c, 1);
      cmd(0, 1, 5);
      I_Data = 32'h1234;
      I_Stall = 1'b1;
      cyc();
      I_Stall = 1'b0;
      cmd(1, 0, 5);
      #1;
      chk("const_stalled_wr", O_Data, 32'hDEADBEEF);
      cmd(1, 0, 9);
      #1;
      chk("oor_data", O_Data, 0);
      chk("oor_rec", O_Re_c, 0);

      I_Scl_Ready = 1'b0;
      I_ThreadID = 4'd7;
      for (int i = 0; i < 4; i++) begin
         cmd(0, 1, 8);
         I_Data = 32'(vals[i]);
         #1;
         chk("out_push_stall", O_Stall, 0);
         cyc();
      end
      I_Data = 32'd5;
      #1;
      chk("out_full_stall", O_Stall, 1);
      chk("out_full_valid", O_Scl_Valid, 1);
      cyc();
      cmd(0, 0, 0);
      I_Scl_Ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("out_valid", O_Scl_Valid, 1);
         chk("out_data", O_Scalar_Data, 32'(vals[i]));
         chk("out_tid", O_Scl_TID, 7);
         cyc();
      end
      chk("out_drained", O_Scl_Valid, 0);
      I_Scl_Ready = 1'b0;

      cmd(1, 0, 8);
      #1;
      chk("in_empty_stall", O_Stall, 1);
      chk("in_empty_data", O_Data, 0);
      cmd(0, 0, 0);
      I_SWe = 1'b1;
      I_Scalar_Data = 32'h55;
      cyc();
      I_SWe = 1'b0;
      cmd(1, 0, 8);
      #1;
      chk("in_rd_data", O_Data, 32'h55);
      chk("in_rd_stall", O_Stall, 0);
      cyc();
      I_SWe = 1'b1;
      I_Scalar_Data = 32'h66;
      #1;
`ifdef AUX_MBOX_BYPASS_EN
      chk("byp_data", O_Data, 32'h66);
      chk("byp_stall", O_Stall, 0);
      cyc();
      I_SWe = 1'b0;
      #1;
      chk("byp_not_queued", O_Stall, 1);
`else
      chk("nobyp_stall", O_Stall, 1);
      chk("nobyp_data", O_Data, 0);
      cyc();
      I_SWe = 1'b0;
      #1;
      chk("nobyp_next_data", O_Data, 32'h66);
      chk("nobyp_next_stall", O_Stall, 0);
      cyc();
`endif
      cmd(0, 0, 0);

      I_SWe = 1'b1;
      for (int i = 0; i < 4; i++) begin
         I_Scalar_Data = 32'hA0 + 32'(i);
         cyc();
      end
      I_Scalar_Data = 32'hBAD;
      #1;
      chk("in_full_srdy", O_SRdy, 0);
      cyc();
      cmd(1, 0, 8);
      I_Scalar_Data = 32'hB0;
      #1;
      chk("in_full_rdpush_srdy", O_SRdy, 1);
      chk("in_full_rdpush_data", O_Data, 32'hA0);
      cyc();
      I_SWe = 1'b0;
      cmd(0, 0, 0);
      #1;
      chk("in_still_full", O_SRdy, 0);
      for (int i = 0; i < 4; i++) begin
         cmd(1, 0, 8);
         #1;
         chk("in_wrap_order", O_Data, in_exp[i]);
         cyc();
      end
      chk("in_drained_stall", O_Stall, 1);
      chk("in_drained_data", O_Data, 0);
      cmd(0, 0, 0);

      I_ThreadID = 4'd3;
      for (int i = 0; i < 2; i++) begin
         cmd(0, 1, 8);
         I_Data = 32'h11 * 32'(i + 1);
         I_SWe = 1'b1;
         I_Scalar_Data = 32'h99;
         cyc();
      end
      cmd(0, 0, 0);
      I_SWe = 1'b0;
      I_Scl_Ready = 1'b1;
      #1;
      chk("mid_head0", O_Scalar_Data, 32'h11);
      cyc();
      chk("mid_head1", O_Scalar_Data, 32'h22);
      reset = 1'b1;
      cyc();
      chk("mid_rst_valid", O_Scl_Valid, 0);
      chk("mid_rst_sdata", O_Scalar_Data, 0);
      chk("mid_rst_tid", O_Scl_TID, 0);
      reset = 1'b0;
      cmd(1, 0, 8);
      #1;
      chk("mid_rst_in_cleared", O_Stall, 1);
      cmd(1, 0, 5);
      #1;
      chk("mid_rst_const", O_Data, 0);
      cmd(0, 0, 0);
      cyc();
      chk("post_rst_valid", O_Scl_Valid, 0);
      chk("post_rst_srdy", O_SRdy, 1);

      for (int k = 0; k < 4; k++) cm[k] = '0;
      for (int n = 0; n < 500; n++) begin
         I_Re = 1'($urandom);
         I_We = 1'($urandom);
         if ($urandom % 5 == 0) I_Src_Command.op = 6'($urandom);
         else I_Src_Command.op = {4'b0011, ($urandom % 2) ? 2'b10 : 2'b11};
         I_Src_Command.src1.v = 1'($urandom);
         I_Src_Command.src1.idx = ($urandom % 3 == 0) ? 5'd8 : 5'($urandom_range(0, 12));
         I_Data = $urandom;
         I_ThreadID = 4'($urandom);
         I_Stall = ($urandom % 4 == 0);
         I_SWe = 1'($urandom);
         I_Scalar_Data = $urandom;
         I_Scl_Ready = ($urandom % 3 != 0);
         #1;
         idx = int'(I_Src_Command.src1.idx);
         rd = I_Re && I_Src_Command.op == 6'b001110;
         wt = I_We && I_Src_Command.op == 6'b001111;
         inc = idx >= 4 && idx < 8;
         mb = idx == 8;
         byp = 1'b0;
`ifdef AUX_MBOX_BYPASS_EN
         byp = rd && mb && inq.size() == 0 && I_SWe;
`endif
         out_pop = outq.size() > 0 && I_Scl_Ready;
         in_pop = rd && mb && inq.size() > 0 && !I_Stall;
         push_out = wt && mb && !I_Stall && (outq.size() < 4 || out_pop);
         srdy = inq.size() < 4 || in_pop;
         stall_e = (wt && mb && outq.size() == 4 && !out_pop) || (rd && mb && inq.size() == 0 && !byp);
         ed = (rd && inc) ? cm[idx-4] : (rd && mb && inq.size() > 0) ? inq[0] : byp ? I_Scalar_Data : '0;
         er = (rd && I_Src_Command.src1.v && idx < 2) ? 2'(1 << idx) : 2'b00;
         chk("rnd_rep", O_Re_p, er);
         chk("rnd_rec", O_Re_c, rd && inc);
         chk("rnd_data", O_Data, ed);
         chk("rnd_stall", O_Stall, stall_e);
         chk("rnd_srdy", O_SRdy, srdy);
         chk("rnd_valid", O_Scl_Valid, outq.size() > 0);
         chk("rnd_sdata", O_Scalar_Data, outq.size() > 0 ? outq[0].data : '0);
         chk("rnd_tid", O_Scl_TID, outq.size() > 0 ? outq[0].tid : '0);
         cyc();
         if (out_pop) void'(outq.pop_front());
         if (push_out) outq.push_back('{data: I_Data, tid: I_ThreadID});
         if (in_pop) void'(inq.pop_front());
         if (I_SWe && srdy && !byp) inq.push_back(I_Scalar_Data);
         if (wt && inc && !I_Stall) cm[idx-4] = I_Data;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
